mux_rr_n: RTL
=============

# mux_rr_n

Registered N-channel, W-bit multiplexer with per-channel valid/ready handshakes and two selection modes: fixed select or round-robin arbitration. It is the parametrised successor to the combinational 8:1 4-bit selector. It sits between several producers and one consumer. The output is registered, giving one cycle of latency, and it sustains one transfer per cycle under continuous consumer readiness.

## Interface
Parameters:
- W, 4, data width per channel.
- N, 8, number of input channels, 2..16.
- SW, 3, select/channel-index width. Must satisfy 2^SW >= N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N*W  flattened channel data; channel k occupies bits [k*W+W-1 : k*W]
- in_valid  input  N  channel k presents data
- in_ready  output  N  channel k's data is accepted this cycle (at most one bit set)
- mode  input  1  0 = fixed select by sel; 1 = round-robin
- sel  input  SW  channel index used when mode = 0
- out_data  output  W  registered selected data
- out_ch  output  SW  index of channel that supplied out_data
- out_valid  output  1  out_data/out_ch hold an item
- out_ready  input  1  consumer accepts item when out_valid & out_ready

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Output register: holds at most one item.
  - load_en = ~out_valid | out_ready.
- Grant (combinational, evaluated every cycle):
  - mode = 0: grant channel sel iff in_valid[sel] and sel < N. If sel >= N, there is no grant.
  - mode = 1: grant the first k with in_valid[k], searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[g] = load_en & grant_valid, for granted channel g only. All other in_ready bits are 0. in_ready never depends on in_valid of other channels beyond the grant search.
- Transfer on in_valid[g] & in_ready[g]:
  - out_data <= channel g data.
  - out_ch <= g.
  - out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1.
  - The pointer updates on accepted transfers in both modes.
- Drain with no grant: if load_en and no grant, out_valid <= 0. out_data and out_ch hold their last values.
- Stall: out_valid & ~out_ready means out_data, out_ch and ptr hold, and all in_ready are 0.
- Mode and sel changes: take effect in the same cycle's grant evaluation. An item already in the output register is unaffected.
- ptr: internal, SW bits, range 0..N-1. It wraps N-1 -> 0 and never holds a value >= N.

## Timing
- Reset values (immediate on rst_n low, independent of clk):
  - out_data = 0
  - out_ch = 0
  - out_valid = 0
  - ptr = 0
  - in_ready = 0, held while rst_n is low.
- Latency: an item accepted at edge t appears on out_data with out_valid = 1 after edge t.
- Throughput: with out_ready held at 1 and a valid channel every cycle, one transfer per cycle with no bubbles.
- Simultaneous drain and load: when out_valid & out_ready and a grant exist in the same cycle, the old item leaves and the new item loads on the same edge. out_valid stays 1.
- Reset mid-operation: any in-flight item is discarded. After rst_n is released, the first round-robin search starts from channel 0.
- in_valid is not required to be held by producers. A channel dropping valid before a grant loses nothing; it is simply not selected.

## Test plan
- Fixed select sweep: mode = 0, out_ready = 1, all in_valid = 1, channel data 4, 8, 1, 15, 3, 7, 0, 14. Step sel 0..7, one per cycle -> out_data follows one cycle later as 4, 8, 1, 15, 3, 7, 0, 14; out_ch = 0..7; exactly one in_ready bit high each cycle.
- Round-robin fairness: mode = 1, all valid, out_ready = 1, starting from reset -> out_ch sequence 0, 1, …, 7, 0, 1 with out_data 4, 8, 1, 15, 3, 7, 0, 14, 4, 8.
- Sparse round-robin with wrap: mode = 1, in_valid = 8'b1000_0101 -> out_ch sequence 0, 2, 7, 0, 2. Pointer wraps 7 -> 0.
- Backpressure: fill the register with channel 3 (data 15), hold out_ready = 0 for 3 cycles -> out_data = 15 and out_valid = 1 stay stable; in_ready = 0; ptr unchanged. Raise out_ready -> next item loads on the same edge the old item drains.
- Empty and invalid select: mode = 0, sel = 2, in_valid[2] = 0 -> no in_ready bit; out_valid falls to 0 after drain. With N = 6 and sel = 7 -> no grant ever.
- Async reset mid-stream: assert rst_n low between edges while out_valid = 1 -> out_valid, out_data and out_ch go to 0 immediately. After release, mode = 1 with all channels valid -> first out_ch = 0.

Source files
------------

// File: rtl/mux_rr_n.sv
// Registered N:1 valid/ready multiplexer with fixed-select or round-robin arbitration.
// One output register stage; sustains one transfer per cycle when the consumer is ready.

module mux_rr_lane #(
    parameter int W   = 4,
    parameter int SW  = 3,
    parameter int IDX = 0
) (
    input  logic          rst_n,
    input  logic [W-1:0]  ch_data_i,
    input  logic          grant_vld_i,
    input  logic [SW-1:0] grant_idx_i,
    input  logic          load_en_i,
    output logic          ready_o,
    output logic [W-1:0]  data_o
);
    logic hit;

    assign hit     = grant_vld_i && (grant_idx_i == SW'(IDX));
    // rst_n gates ready so producers see no acceptance while reset is held.
    assign ready_o = rst_n & load_en_i & hit;
    assign data_o  = hit ? ch_data_i : '0;
endmodule

module mux_rr_n #(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam logic [SW-1:0] LAST = SW'(N-1);

    logic [W-1:0]          out_data_q, out_data_d;
    logic [SW-1:0]         out_ch_q, out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [SW-1:0]         ptr_q, ptr_d;

    logic                  load_en, xfer;
    logic                  fix_vld, rr_vld, grant_vld;
    logic [SW-1:0]         rr_idx, grant_idx, scan_idx;
    logic [N-1:0][W-1:0]   lane_data;
    logic [W-1:0]          sel_data;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

    assign load_en = ~out_valid_q | out_ready;

    // Comparing against every legal index means sel >= N simply never matches.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k) && in_valid[k]) fix_vld = 1'b1;
        end
    end

    always_comb begin
        rr_vld   = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = wrap_add(ptr_q, i);
            if (!rr_vld && in_valid[scan_idx]) begin
                rr_vld = 1'b1;
                rr_idx = scan_idx;
            end
        end
    end

    assign grant_vld = mode ? rr_vld : fix_vld;
    assign grant_idx = mode ? rr_idx : sel;
    assign xfer      = load_en & grant_vld;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            mux_rr_lane #(.W(W), .SW(SW), .IDX(g)) u_lane (
                .rst_n       (rst_n),
                .ch_data_i   (in_data[g*W +: W]),
                .grant_vld_i (grant_vld),
                .grant_idx_i (grant_idx),
                .load_en_i   (load_en),
                .ready_o     (in_ready[g]),
                .data_o      (lane_data[g])
            );
        end
    endgenerate

    // At most one lane is non-zero, so an OR tree acts as the data mux.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N; k++) sel_data = sel_data | lane_data[k];
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) out_valid_d = grant_vld;
        if (xfer) begin
            out_data_d = sel_data;
            out_ch_d   = grant_idx;
            ptr_d      = (grant_idx == LAST) ? '0 : grant_idx + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
endmodule
